// File: rtl/dsp_branch_unit.sv
// dsp_branch_unit: flow-control unit between decode/ALU and fetch.
// Registered jump strobe, flush window and return-address stack.
module dsp_branch_unit #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int STACK_DEPTH  = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [2:0]        flow_mode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [ADDR_W-1:0] address,
  input  logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              jump_flag,
  output logic              flush,
  output logic              busy,
  output logic              stack_overflow,
  output logic              stack_underflow
);

  localparam int PTR_W  = $clog2(STACK_DEPTH);
  localparam int SCNT_W = $clog2(STACK_DEPTH + 1);
  localparam int CNT_W  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [PTR_W-1:0] LAST_PTR =
    PTR_W'(STACK_DEPTH - 1);
  localparam logic [SCNT_W-1:0] FULL_CNT =
    SCNT_W'(STACK_DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [ADDR_W-1:0] jaddr_q;
  logic [ADDR_W-1:0] jaddr_d;
  logic              jflag_q;
  logic              jflag_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              udf_q;
  logic              udf_d;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_d;
  logic [SCNT_W-1:0] scnt_q;
  logic [SCNT_W-1:0] scnt_d;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  logic              push;
  logic              pop;
  logic              taken;
  logic [ADDR_W-1:0] target;

  logic is_jmp;
  logic is_bez;
  logic is_bnez;
  logic is_bltz;
  logic is_call;
  logic is_ret;

  logic alu_zero;
  logic stk_empty;
  logic stk_full;
  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;
  logic [ADDR_W-1:0] stk_top;

  assign is_jmp  = (flow_mode == 3'd1);
  assign is_bez  = (flow_mode == 3'd2);
  assign is_bnez = (flow_mode == 3'd3);
  assign is_bltz = (flow_mode == 3'd4);
  assign is_call = (flow_mode == 3'd5);
  assign is_ret  = (flow_mode == 3'd6);

  assign alu_zero  = (alu_result == '0);
  assign stk_empty = (scnt_q == '0);
  assign stk_full  = (scnt_q == FULL_CNT);

  // ptr_q is the next write slot; the top of stack sits just below it
  assign ptr_inc = (ptr_q == LAST_PTR) ?
                   '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ?
                   LAST_PTR : ptr_q - 1'b1;
  assign stk_top = stack_mem[ptr_dec];

  // branch evaluation, stack bookkeeping and next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    jaddr_d = jaddr_q;
    jflag_d = 1'b0;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    ptr_d   = ptr_q;
    scnt_d  = scnt_q;
    push    = 1'b0;
    pop     = 1'b0;
    taken   = 1'b0;
    target  = address;

    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          unique case (1'b1)
            is_jmp:  taken = 1'b1;
            is_bez:  taken = alu_zero;
            is_bnez: taken = !alu_zero;
            is_bltz: taken = alu_result[DATA_W-1];
            is_call: begin
              taken = 1'b1;
              push  = 1'b1;
            end
            is_ret: begin
              if (stk_empty) begin
                udf_d = 1'b1;
              end else begin
                taken  = 1'b1;
                target = stk_top;
                pop    = 1'b1;
              end
            end
            default: ;
          endcase
          if (taken) begin
            jaddr_d = target;
            jflag_d = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // a full stack overwrites its oldest slot and stays full
    if (push) begin
      ptr_d = ptr_inc;
      if (stk_full) begin
        ovf_d = 1'b1;
      end else begin
        scnt_d = scnt_q + 1'b1;
      end
    end

    if (pop) begin
      ptr_d  = ptr_dec;
      scnt_d = scnt_q - 1'b1;
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      jaddr_q <= '0;
      jflag_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      ptr_q   <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      jaddr_q <= jaddr_d;
      jflag_q <= jflag_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      ptr_q   <= ptr_d;
      scnt_q  <= scnt_d;
    end
  end

  // return-address storage; contents are dead once the count is cleared
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      stack_mem[ptr_q] <= pc_next;
    end
  end

  assign jump_addr       = jaddr_q;
  assign jump_flag       = jflag_q;
  assign flush           = (state_q == FLUSH);
  assign busy            = flush && !jflag_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = udf_q;

endmodule

// File: tb/tb_dsp_branch_unit.sv
// tb_dsp_branch_unit: directed vectors, queued expected jump targets
// checked by an independent negedge monitor.
module tb_dsp_branch_unit;

  localparam logic [2:0] M_NONE = 3'd0;
  localparam logic [2:0] M_JMP  = 3'd1;
  localparam logic [2:0] M_BEZ  = 3'd2;
  localparam logic [2:0] M_BNEZ = 3'd3;
  localparam logic [2:0] M_BLTZ = 3'd4;
  localparam logic [2:0] M_CALL = 3'd5;
  localparam logic [2:0] M_RET  = 3'd6;
  localparam logic [2:0] M_RSV  = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [2:0]  flow_mode = 3'd0;
  logic [15:0] alu_result = 16'h0;
  logic [15:0] address = 16'h0;
  logic [15:0] pc_next = 16'h0;
  logic [15:0] jump_addr;
  logic        jump_flag;
  logic        flush;
  logic        busy;
  logic        stack_overflow;
  logic        stack_underflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q [$];

  dsp_branch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .valid_in        (valid_in),
    .flow_mode       (flow_mode),
    .alu_result      (alu_result),
    .address         (address),
    .pc_next         (pc_next),
    .jump_addr       (jump_addr),
    .jump_flag       (jump_flag),
    .flush           (flush),
    .busy            (busy),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: act=%h req=%h", nm, act, req);
    end
  endtask

  // monitor: every jump strobe must match the oldest queued target
  always @(negedge clk) begin
    if (jump_flag === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_jump: act=%h req=none",
                 jump_addr);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (jump_addr !== e) begin
          n_fail++;
          $display("FAIL jump_addr: act=%h req=%h", jump_addr, e);
        end
      end
    end
  end

  task automatic op(input logic [2:0] m, input logic [15:0] alu,
                    input logic [15:0] a, input logic [15:0] pc,
                    input bit tk, input logic [15:0] tgt);
    @(negedge clk);
    chk("idle_flush", {15'b0, flush}, 16'd0);
    valid_in   = 1'b1;
    flow_mode  = m;
    alu_result = alu;
    address    = a;
    pc_next    = pc;
    if (tk) exp_q.push_back(tgt);
    @(negedge clk);
    valid_in = 1'b0;
    chk("jflag", {15'b0, jump_flag}, {15'b0, tk});
    chk("flush1", {15'b0, flush}, {15'b0, tk});
    chk("busy1", {15'b0, busy}, 16'd0);
    if (tk) begin
      @(negedge clk);
      chk("jflag2", {15'b0, jump_flag}, 16'd0);
      chk("flush2", {15'b0, flush}, 16'd1);
      chk("busy2", {15'b0, busy}, 16'd1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_addr"}, jump_addr, 16'h0);
    chk({nm, "_jf"}, {15'b0, jump_flag}, 16'd0);
    chk({nm, "_fl"}, {15'b0, flush}, 16'd0);
    chk({nm, "_busy"}, {15'b0, busy}, 16'd0);
    chk({nm, "_ovf"}, {15'b0, stack_overflow}, 16'd0);
    chk({nm, "_udf"}, {15'b0, stack_underflow}, 16'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    op(M_JMP,  16'h0000, 16'h0123, 16'h0000, 1, 16'h0123);
    op(M_BEZ,  16'h0000, 16'h0200, 16'h0000, 1, 16'h0200);
    op(M_BEZ,  16'h0001, 16'h0210, 16'h0000, 0, 16'h0000);
    op(M_BEZ,  16'h0100, 16'h0220, 16'h0000, 0, 16'h0000);
    chk("hold_addr", jump_addr, 16'h0200);
    op(M_BNEZ, 16'h0001, 16'h0230, 16'h0000, 1, 16'h0230);
    op(M_BNEZ, 16'h0000, 16'h0240, 16'h0000, 0, 16'h0000);
    op(M_BNEZ, 16'h8000, 16'h0250, 16'h0000, 1, 16'h0250);
    op(M_BLTZ, 16'h8000, 16'h0260, 16'h0000, 1, 16'h0260);
    op(M_BLTZ, 16'h7FFF, 16'h0270, 16'h0000, 0, 16'h0000);
    op(M_NONE, 16'h0000, 16'h0280, 16'h0000, 0, 16'h0000);
    op(M_RSV,  16'h0000, 16'h0290, 16'h0000, 0, 16'h0000);

    // CALL presented during both flush cycles must be squashed
    @(negedge clk);
    valid_in  = 1'b1;
    flow_mode = M_JMP;
    address   = 16'h0400;
    exp_q.push_back(16'h0400);
    @(negedge clk);
    flow_mode = M_CALL;
    address   = 16'h0500;
    pc_next   = 16'h0501;
    @(negedge clk);
    chk("sq_jf2", {15'b0, jump_flag}, 16'd0);
    @(negedge clk);
    valid_in = 1'b0;
    chk("sq_jf3", {15'b0, jump_flag}, 16'd0);
    chk("sq_fl3", {15'b0, flush}, 16'd0);

    op(M_CALL, 16'h0000, 16'h0010, 16'h0005, 1, 16'h0010);
    op(M_CALL, 16'h0000, 16'h0020, 16'h0011, 1, 16'h0020);
    op(M_RET,  16'h0000, 16'h0000, 16'h0000, 1, 16'h0011);
    op(M_RET,  16'h0000, 16'h0000, 16'h0000, 1, 16'h0005);
    chk("udf_pre", {15'b0, stack_underflow}, 16'd0);
    op(M_RET,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    chk("udf_set", {15'b0, stack_underflow}, 16'd1);
    op(M_JMP,  16'h0000, 16'h0600, 16'h0000, 1, 16'h0600);
    chk("udf_sticky", {15'b0, stack_underflow}, 16'd1);
    chk("ovf_clear", {15'b0, stack_overflow}, 16'd0);

    do_reset();
    for (int i = 1; i <= 5; i++) begin
      op(M_CALL, 16'h0000, 16'(16'h0100 + i), 16'(i), 1,
         16'(16'h0100 + i));
      if (i == 4)
        chk("ovf_at4", {15'b0, stack_overflow}, 16'd0);
    end
    chk("ovf_at5", {15'b0, stack_overflow}, 16'd1);
    for (int i = 5; i >= 2; i--) begin
      op(M_RET, 16'h0000, 16'h0000, 16'h0000, 1, 16'(i));
    end
    chk("udf_before5", {15'b0, stack_underflow}, 16'd0);
    op(M_RET, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    chk("udf_after5", {15'b0, stack_underflow}, 16'd1);
    chk("ovf_sticky", {15'b0, stack_overflow}, 16'd1);

    // reset in the middle of a CALL flush window
    do_reset();
    @(negedge clk);
    valid_in  = 1'b1;
    flow_mode = M_CALL;
    address   = 16'h0300;
    pc_next   = 16'h0301;
    exp_q.push_back(16'h0300);
    @(negedge clk);
    valid_in = 1'b0;
    chk("rf_flush", {15'b0, flush}, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid");
    rst = 1'b0;
    op(M_RET, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    chk("rst_udf", {15'b0, stack_underflow}, 16'd1);

    repeat (3) @(negedge clk);
    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
